// File: rtl/gtech_scan_shift_ctrl.sv
// gtech_scan_shift_ctrl: scan-chain load/unload controller.
// Accepts one parallel request word, shifts it into a CHAIN_LEN-long
// scan chain through TI/TE, and captures the chain's previous contents
// from SO. That capture is returned as a parallel response word.
// Optional feature macro: SCAN_SHIFT_PARITY_EN adds rsp_parity, which is
// the XOR of all unloaded bits, accumulated serially during the shift.
module gtech_scan_shift_ctrl #(
  parameter  int CHAIN_LEN = 16,
  localparam int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 CP,
  input  logic                 CD,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CHAIN_LEN-1:0] req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 TE,
  output logic                 TI,
  input  logic                 SO,
  output logic                 busy
`ifdef SCAN_SHIFT_PARITY_EN
  ,
  output logic                 rsp_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_shift;

  // The final shift edge is the one taken while the counter shows CHAIN_LEN-1.
  assign last_shift = (cnt_q == CNT_W'(CHAIN_LEN - 1));

  // State register: CD clears the controller immediately, even mid-shift.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: there is no IDLE bypass, so every response passes through IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)              state_d = SHIFT;
      SHIFT:   if (last_shift)             state_d = RESP;
      RESP:    if (rsp_ready)              state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Output decode: every output comes from registered state, so TE/TI stay stable for the whole cycle.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    TE        = 1'b0;
    TI        = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      SHIFT: begin
        TE   = 1'b1;
        TI   = shreg_q[CHAIN_LEN-1];
        busy = 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // The shift register holds the outgoing word and fills with SO. After the last edge it holds the unloaded word.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          shreg_d = req_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[CHAIN_LEN-2:0], SO};
        if (!last_shift) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        shreg_d = shreg_q;
      end
    endcase
  end

  // Datapath registers: shift word and shift counter.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_data = shreg_q;

`ifdef SCAN_SHIFT_PARITY_EN
  logic parity_q, parity_d;

  // Parity accumulator: cleared on accept, then it folds in each SO bit as that bit is captured.
  always_comb begin
    parity_d = parity_q;
    if (state_q == IDLE && req_valid) begin
      parity_d = 1'b0;
    end else if (state_q == SHIFT) begin
      parity_d = parity_q ^ SO;
    end
  end

  // Parity register: it stays valid alongside rsp_valid until the next accept.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign rsp_parity = parity_q;
`endif

endmodule
